// File: rtl/rng_arbiter_if.sv
// Requester-side bus of the shared random-nibble scheduler.
// Master drives seed/req; slave (the arbiter) returns grants, data and status.
interface rng_arbiter_if #(
    parameter int NREQ = 4
);
    logic [3:0]      seed;
    logic            seed_load;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
    logic            rnd_valid;
    logic [3:0]      rnd_data;
    logic            ready;
    logic            busy;
    logic [3:0]      lfsr_state;

    modport master (
        output seed, seed_load, req,
        input  gnt, rnd_valid, rnd_data, ready, busy, lfsr_state
    );

    modport slave (
        input  seed, seed_load, req,
        output gnt, rnd_valid, rnd_data, ready, busy, lfsr_state
    );
endinterface

// File: rtl/rng_arbiter.sv
// Round-robin scheduler sharing one 4-bit LFSR (x^4+x^3+1) between NREQ requesters;
// each grant is preceded by STEPS shifts, each seed load by WARMUP shifts.
module rng_arbiter #(
    parameter int NREQ   = 4,
    parameter int STEPS  = 4,
    parameter int WARMUP = 8
) (
    input  logic          clk,
    input  logic          reset,
    rng_arbiter_if.slave  bus
);
    localparam int PW = $clog2(NREQ);

    typedef enum logic [2:0] {UNSEEDED, WARM, IDLE, STEP, DELIVER} state_t;

    state_t          state, state_nx;
    logic [3:0]      lfsr, lfsr_nx;
    logic [3:0]      cnt, cnt_nx;
    logic [PW-1:0]   ptr, ptr_nx;
    logic [PW-1:0]   winner, winner_nx;
    logic [NREQ-1:0] gnt, gnt_nx;
    logic            rnd_valid, rnd_valid_nx;
    logic [3:0]      rnd_data, rnd_data_nx;
    logic [PW:0]     pick;

    // A zero register would lock the LFSR forever, so it is pushed back onto the cycle.
    function automatic logic [3:0] lfsr_shift(input logic [3:0] s);
        if (s == 4'b0000) return 4'b0001;
        return {s[2:0], s[3] ^ s[2]};
    endfunction

    // Returns {found, index} of the first set request after p, wrapping modulo NREQ.
    function automatic logic [PW:0] rr_pick(input logic [NREQ-1:0] r, input logic [PW-1:0] p);
        logic [PW:0] res;
        int          j;
        res = '0;
        for (int i = NREQ; i >= 1; i--) begin
            j = (int'(p) + i) % NREQ;
            if (r[j]) res = {1'b1, PW'(j)};
        end
        return res;
    endfunction

    assign pick = rr_pick(bus.req, ptr);

    always_comb begin
        state_nx     = state;
        lfsr_nx      = lfsr;
        cnt_nx       = cnt;
        ptr_nx       = ptr;
        winner_nx    = winner;
        gnt_nx       = '0;
        rnd_valid_nx = 1'b0;
        rnd_data_nx  = 4'b0000;

        case (state)
            UNSEEDED: ;
            WARM: begin
                lfsr_nx = lfsr_shift(lfsr);
                cnt_nx  = cnt + 4'd1;
                if (cnt == 4'(WARMUP - 1)) state_nx = IDLE;
            end
            IDLE: begin
                if (pick[PW]) begin
                    winner_nx = pick[PW-1:0];
                    cnt_nx    = 4'd0;
                    state_nx  = STEP;
                end
            end
            STEP: begin
                lfsr_nx = lfsr_shift(lfsr);
                cnt_nx  = cnt + 4'd1;
                if (cnt == 4'(STEPS - 1)) begin
                    state_nx     = DELIVER;
                    gnt_nx       = NREQ'(1) << winner;
                    rnd_valid_nx = 1'b1;
                    rnd_data_nx  = lfsr_nx;
                end
            end
            DELIVER: begin
                ptr_nx   = winner;
                state_nx = IDLE;
            end
            default: state_nx = UNSEEDED;
        endcase

        // Seeding overrides everything; a grant already on the wire still retires the pointer.
        if (bus.seed_load) begin
            lfsr_nx      = (bus.seed == 4'b0000) ? 4'b0001 : bus.seed;
            cnt_nx       = 4'd0;
            state_nx     = WARM;
            gnt_nx       = '0;
            rnd_valid_nx = 1'b0;
            rnd_data_nx  = 4'b0000;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= UNSEEDED;
            lfsr      <= 4'b0000;
            cnt       <= 4'd0;
            ptr       <= PW'(NREQ - 1);
            winner    <= '0;
            gnt       <= '0;
            rnd_valid <= 1'b0;
            rnd_data  <= 4'b0000;
        end else begin
            state     <= state_nx;
            lfsr      <= lfsr_nx;
            cnt       <= cnt_nx;
            ptr       <= ptr_nx;
            winner    <= winner_nx;
            gnt       <= gnt_nx;
            rnd_valid <= rnd_valid_nx;
            rnd_data  <= rnd_data_nx;
        end
    end

    assign bus.gnt        = gnt;
    assign bus.rnd_valid  = rnd_valid;
    assign bus.rnd_data   = rnd_data;
    assign bus.ready      = (state == IDLE) || (state == STEP) || (state == DELIVER);
    assign bus.busy       = (state != IDLE);
    assign bus.lfsr_state = lfsr;
endmodule

// File: tb/tb_rng_arbiter.sv
// Scoreboard bench for rng_arbiter: stimulus pushes expected grants from a
// sequence-level model, a monitor pops and compares on every grant.
module tb_rng_arbiter;
    localparam int NREQ   = 4;
    localparam int STEPS  = 4;
    localparam int WARMUP = 8;

    logic clk;
    logic reset;

    rng_arbiter_if #(.NREQ(NREQ)) bus();

    rng_arbiter #(.NREQ(NREQ), .STEPS(STEPS), .WARMUP(WARMUP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int         idx;
        logic [3:0] data;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: LFSR as a number sequence, round-robin as rotation order.
    logic [3:0] m_lfsr;
    int         m_ptr;

    function automatic logic [3:0] m_next(input logic [3:0] v);
        int x;
        x = int'(v);
        if (x == 0) return 4'd1;
        return 4'(((x * 2) % 16) + (((x >> 3) & 1) ^ ((x >> 2) & 1)));
    endfunction

    function automatic logic [3:0] m_advance(input logic [3:0] v, input int n);
        logic [3:0] r;
        r = v;
        for (int i = 0; i < n; i++) r = m_next(r);
        return r;
    endfunction

    task automatic push_expected(input logic [NREQ-1:0] mask);
        int base;
        base = m_ptr;
        for (int i = 1; i <= NREQ; i++) begin
            int j;
            j = (base + i) % NREQ;
            if (mask[j]) begin
                m_lfsr = m_advance(m_lfsr, STEPS);
                exp_q.push_back('{idx: j, data: m_lfsr});
                m_ptr = j;
            end
        end
    endtask

    // Requesters: stimulus raises req_set; monitor drops each bit once granted.
    logic [NREQ-1:0] req_set;
    logic [NREQ-1:0] served = '0;
    assign bus.req = req_set & ~served;

    int   cyc = 0;
    int   last_gnt_cyc = 0;
    logic rr_pending = 1'b0;
    exp_t mon_e;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (!reset) begin
            if (bus.gnt != '0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_gnt", 32'(bus.gnt), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("gnt", 32'(bus.gnt), 32'(1) << mon_e.idx);
                    check("rnd_data", 32'(bus.rnd_data), 32'(mon_e.data));
                    check("rnd_valid", 32'(bus.rnd_valid), 32'd1);
                end
                if (rr_pending) check("grant_spacing", 32'(cyc - last_gnt_cyc), 32'(STEPS + 2));
                last_gnt_cyc = cyc;
                rr_pending   = ((bus.req & ~bus.gnt) != '0);
            end else if (bus.rnd_valid || bus.rnd_data != 4'b0000) begin
                check("idle_outputs", {27'd0, bus.rnd_valid, bus.rnd_data}, 32'd0);
            end
            served = (served | bus.gnt) & req_set;
        end
    end

    task automatic load_seed(input logic [3:0] s);
        bus.seed      = s;
        bus.seed_load = 1'b1;
        @(negedge clk);
        bus.seed_load = 1'b0;
        check("ready_low_after_load", 32'(bus.ready), 32'd0);
        check("seed_loaded", 32'(bus.lfsr_state), (s == 4'b0000) ? 32'd1 : 32'(s));
        m_lfsr = m_advance((s == 4'b0000) ? 4'b0001 : s, WARMUP);
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!bus.ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("ready_timeout", 32'd0, 32'd1);
        check("warm_lfsr", 32'(bus.lfsr_state), 32'(m_lfsr));
        check("busy_idle", 32'(bus.busy), 32'd0);
    endtask

    task automatic wait_served(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((bus.req != '0 || exp_q.size() != 0) && n < 200);
        if (n >= 200) check("served_timeout", 32'd0, 32'd1);
        req_set = '0;
        @(negedge clk);
    endtask

    task automatic wait_gnt();
        int n;
        n = 0;
        while (bus.gnt == '0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("gnt_timeout", 32'd0, 32'd1);
    endtask

    task automatic issue(input logic [NREQ-1:0] mask, output int lat);
        push_expected(mask);
        req_set = mask;
        wait_served(lat);
    endtask

    initial begin
        int n;
        int b;
        reset         = 1'b1;
        bus.seed      = 4'b0000;
        bus.seed_load = 1'b0;
        req_set       = '0;
        m_lfsr        = 4'b0000;
        m_ptr         = NREQ - 1;

        #12;
        check("rst_gnt", 32'(bus.gnt), 32'd0);
        check("rst_rnd_valid", 32'(bus.rnd_valid), 32'd0);
        check("rst_rnd_data", 32'(bus.rnd_data), 32'd0);
        check("rst_ready", 32'(bus.ready), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd1);
        check("rst_lfsr", 32'(bus.lfsr_state), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Unseeded: requests must be ignored.
        req_set = '1;
        repeat (100) @(negedge clk);
        check("unseeded_ready", 32'(bus.ready), 32'd0);
        check("unseeded_lfsr", 32'(bus.lfsr_state), 32'd0);
        req_set = '0;
        @(negedge clk);

        // First seed, warm-up length, then two single-requester deliveries.
        load_seed(4'b1001);
        wait_ready(n);
        check("warmup_len", 32'(n), 32'(WARMUP));
        issue(4'b0001, n);
        check("latency", 32'(n), 32'(STEPS + 1));
        issue(4'b0001, n);
        check("latency2", 32'(n), 32'(STEPS + 1));

        // Round-robin over all requesters, twice.
        issue('1, n);
        issue('1, n);

        // Zero seed maps to 0001.
        load_seed(4'b0000);
        wait_ready(n);

        // Zero-lock guard: clear the LFSR at the start of STEP.
        req_set = 4'b0100;
        @(negedge clk);
        dut.lfsr = 4'b0000;
        m_lfsr   = 4'b0000;
        push_expected(4'b0100);
        @(negedge clk);
        check("zero_lock", 32'(bus.lfsr_state), 32'd1);
        wait_served(n);

        // Reseed during STEP: request abandoned, served later from the new seed.
        b = 1;
        req_set = NREQ'(1) << b;
        @(negedge clk);
        load_seed(4'b0110);
        wait_ready(n);
        check("reseed_step_warmup", 32'(n), 32'(WARMUP));
        push_expected(NREQ'(1) << b);
        wait_served(n);

        // Reseed during DELIVER: grant completes, then warm-up.
        push_expected(4'b1000);
        req_set = 4'b1000;
        wait_gnt();
        load_seed(4'b1100);
        req_set = '0;
        wait_ready(n);
        issue('1, n);

        // Asynchronous reset while a grant is on the bus.
        push_expected(4'b0010);
        req_set = 4'b0010;
        wait_gnt();
        #1 reset = 1'b1;
        #1;
        check("arst_gnt", 32'(bus.gnt), 32'd0);
        check("arst_rnd_valid", 32'(bus.rnd_valid), 32'd0);
        check("arst_ready", 32'(bus.ready), 32'd0);
        check("arst_busy", 32'(bus.busy), 32'd1);
        check("arst_lfsr", 32'(bus.lfsr_state), 32'd0);
        req_set = '0;
        m_ptr   = NREQ - 1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        load_seed(4'b0011);
        wait_ready(n);
        issue('1, n);

        // Randomized batches with occasional reseeding.
        for (int k = 0; k < 14; k++) begin
            if ($urandom_range(0, 2) == 0) begin
                load_seed(4'($urandom_range(0, 15)));
                wait_ready(n);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            issue(NREQ'($urandom_range(1, (1 << NREQ) - 1)), n);
        end

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
